// File: rtl/horner_coeff_sequencer_if.sv
// Handshake and datapath-control bundle between the Horner sequencer (master)
// and the coefficient mux / MAC datapath (slave).
interface horner_coeff_sequencer_if #(
  parameter int SEL_W = 4
);
  logic             srdyi_i;
  logic             busy_o;
  logic             x_load_o;
  logic [SEL_W-1:0] coeff_select_o;
  logic             acc_clr_o;
  logic             mac_en_o;
  logic             srdyo_o;

  modport master (
    input  srdyi_i,
    output busy_o,
    output x_load_o,
    output coeff_select_o,
    output acc_clr_o,
    output mac_en_o,
    output srdyo_o
  );

  modport slave (
    output srdyi_i,
    input  busy_o,
    input  x_load_o,
    input  coeff_select_o,
    input  acc_clr_o,
    input  mac_en_o,
    input  srdyo_o
  );
endinterface

// File: rtl/horner_coeff_sequencer.sv
// Horner-rule sequencer: walks coeff_select from NUM_COEFF-1 down to 0, one MAC per step.
// Optional macro HORNER_PENDING_REQ_EN adds a one-deep pending request captured while busy.
module horner_coeff_sequencer #(
  parameter int NUM_COEFF = 11,
  parameter int SEL_W     = 4,
  parameter int MUL_LAT   = 2
) (
  input  logic                      Clock,
  input  logic                      GlobalReset,
  horner_coeff_sequencer_if.master  seq
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int               CNT_W     = 3;
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_COEFF - 1);
  localparam logic [SEL_W-1:0] IDX_ONE   = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             x_load_q, x_load_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             clr_q, clr_d;
  logic             mac_q, mac_d;
  logic             srdyo_q, srdyo_d;

  logic             restart;

`ifdef HORNER_PENDING_REQ_EN
  logic pending_q, pending_d;

  // A request in DONE is served immediately by restarting; otherwise it is parked.
  assign restart = pending_q | seq.srdyi_i;

  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_DONE) begin
      pending_d = 1'b0;
    end else if ((state_q != ST_IDLE) && seq.srdyi_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (GlobalReset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign restart = 1'b0;
`endif

  // Next-state logic. idx holds the step being issued (and held through WAIT).
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (seq.srdyi_i) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_ISSUE;
        idx_d   = LAST_IDX;
      end
      ST_ISSUE: begin
        if (MUL_LAT > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end else if (idx_q == '0) begin
          state_d = ST_DONE;
          idx_d   = LAST_IDX;
        end else begin
          state_d = ST_ISSUE;
          idx_d   = idx_q - IDX_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (idx_q == '0) begin
          state_d = ST_DONE;
          idx_d   = LAST_IDX;
        end else begin
          state_d = ST_ISSUE;
          idx_d   = idx_q - IDX_ONE;
        end
      end
      ST_DONE: begin
        state_d = restart ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = LAST_IDX;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they belong to.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    x_load_d = (state_d == ST_LOAD);
    mac_d    = (state_d == ST_ISSUE);
    clr_d    = (state_d == ST_ISSUE) && (idx_d == LAST_IDX);
    srdyo_d  = (state_d == ST_DONE);
    sel_d    = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) ? idx_d : '0;
  end

  always_ff @(posedge Clock) begin
    // NOTE: reset is synchronous here; GlobalReset is only looked at on the rising edge.
    if (GlobalReset) begin
      state_q  <= ST_IDLE;
      idx_q    <= LAST_IDX;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      x_load_q <= 1'b0;
      sel_q    <= '0;
      clr_q    <= 1'b0;
      mac_q    <= 1'b0;
      srdyo_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      x_load_q <= x_load_d;
      sel_q    <= sel_d;
      clr_q    <= clr_d;
      mac_q    <= mac_d;
      srdyo_q  <= srdyo_d;
    end
  end

  assign seq.busy_o         = busy_q;
  assign seq.x_load_o       = x_load_q;
  assign seq.coeff_select_o = sel_q;
  assign seq.acc_clr_o      = clr_q;
  assign seq.mac_en_o       = mac_q;
  assign seq.srdyo_o        = srdyo_q;

  // Schedule invariants: result strobe is single-cycle, load precedes the clearing MAC.
  a_srdyo_pulse : assert property (@(posedge Clock) disable iff (GlobalReset)
    srdyo_q |=> !srdyo_q);
  a_load_then_clr : assert property (@(posedge Clock) disable iff (GlobalReset)
    x_load_q |=> (mac_q && clr_q));
  a_no_overlap : assert property (@(posedge Clock) disable iff (GlobalReset)
    !(mac_q && x_load_q));

endmodule

// File: tb/tb_horner_coeff_sequencer.sv
// Bench for horner_coeff_sequencer: default instance (11 coeffs, MUL_LAT=2) and a
// small instance (4 coeffs, MUL_LAT=0), both checked every cycle against a timing model.
module tb_horner_coeff_sequencer;

`ifdef HORNER_PENDING_REQ_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       x_load;
    logic [3:0] sel;
    logic       clr;
    logic       mac;
    logic       srdyo;
  } outs_t;

  typedef struct {
    int          e0;
    int          done;
    int          macs;
    logic [63:0] sels;
    longint      acc;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s;
  horner_coeff_sequencer_if #(.SEL_W(4)) bus_b ();
  horner_coeff_sequencer_if #(.SEL_W(4)) bus_s ();

  horner_coeff_sequencer #(.NUM_COEFF(11), .SEL_W(4), .MUL_LAT(2)) dut_b (
    .Clock(clk), .GlobalReset(rst_b), .seq(bus_b)
  );
  horner_coeff_sequencer #(.NUM_COEFF(4), .SEL_W(4), .MUL_LAT(0)) dut_s (
    .Clock(clk), .GlobalReset(rst_s), .seq(bus_s)
  );

  outs_t act_o [2];
  logic  in_req [2];
  logic  in_rst [2];
  assign act_o[0] = {bus_b.busy_o, bus_b.x_load_o, bus_b.coeff_select_o,
                     bus_b.acc_clr_o, bus_b.mac_en_o, bus_b.srdyo_o};
  assign act_o[1] = {bus_s.busy_o, bus_s.x_load_o, bus_s.coeff_select_o,
                     bus_s.acc_clr_o, bus_s.mac_en_o, bus_s.srdyo_o};
  assign in_req[0] = bus_b.srdyi_i;
  assign in_req[1] = bus_s.srdyi_i;
  assign in_rst[0] = rst_b;
  assign in_rst[1] = rst_s;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nc(input int i);
    return (i == 0) ? 11 : 4;
  endfunction
  function automatic int ml(input int i);
    return (i == 0) ? 2 : 0;
  endfunction
  function automatic string tag(input int i);
    return (i == 0) ? "big" : "small";
  endfunction

  // Model: an evaluation is just a start cycle (the LOAD cycle); everything else
  // follows arithmetically from the offset into the evaluation.
  bit m_act  [2] = '{0, 0};
  bit m_pend [2] = '{0, 0};
  int m_start[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int done_off;
      done_off = 1 + nc(i) * (1 + ml(i));
      if (in_rst[i]) begin
        m_act[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end else if (m_act[i] && (cyc - m_start[i] == done_off)) begin
        if (PEND_EN && (m_pend[i] || in_req[i])) begin
          m_start[i] = cyc + 1;
          m_pend[i]  = 1'b0;
        end else begin
          m_act[i] = 1'b0;
        end
      end else if (m_act[i]) begin
        if (PEND_EN && in_req[i]) m_pend[i] = 1'b1;
      end else if (in_req[i]) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc + 1;
      end
    end
    cyc = cyc + 1;
  end

  function automatic outs_t model_out(input int i, input int c);
    outs_t e;
    int n, span, d, k;
    e = '0;
    if (!m_act[i]) return e;
    n    = nc(i);
    span = 1 + ml(i);
    d    = c - m_start[i];
    e.busy = 1'b1;
    if (d == 0) begin
      e.x_load = 1'b1;
    end else if (d == 1 + n * span) begin
      e.srdyo = 1'b1;
    end else begin
      k     = (d - 1) / span;
      e.sel = 4'(n - 1 - k);
      e.mac = ((d - 1) % span) == 0;
      e.clr = e.mac && (k == 0);
    end
    return e;
  endfunction

  // The one compare process: every cycle, every output of both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      outs_t e, a;
      e = model_out(i, cyc);
      a = act_o[i];
      check($sformatf("%s.busy", tag(i)),   64'(a.busy),   64'(e.busy));
      check($sformatf("%s.x_load", tag(i)), 64'(a.x_load), 64'(e.x_load));
      check($sformatf("%s.sel", tag(i)),    64'(a.sel),    64'(e.sel));
      check($sformatf("%s.clr", tag(i)),    64'(a.clr),    64'(e.clr));
      check($sformatf("%s.mac", tag(i)),    64'(a.mac),    64'(e.mac));
      check($sformatf("%s.srdyo", tag(i)),  64'(a.srdyo),  64'(e.srdyo));
    end
  end

  // Datapath stand-in (coeff_k = k, x = 2) and per-evaluation log, driven by DUT strobes.
  rec_t        log_b[$];
  rec_t        log_s[$];
  int          cur_e0  [2];
  int          cur_macs[2];
  logic [63:0] cur_sels[2];
  longint      cur_acc [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      outs_t o;
      rec_t  r;
      o = act_o[i];
      if (o.x_load === 1'b1) begin
        cur_e0[i]   = cyc - 1;
        cur_macs[i] = 0;
        cur_sels[i] = '0;
        cur_acc[i]  = 0;
      end
      if (o.mac === 1'b1) begin
        cur_macs[i] = cur_macs[i] + 1;
        cur_sels[i] = {cur_sels[i][59:0], o.sel};
        cur_acc[i]  = (o.clr ? 64'sd0 : cur_acc[i]) * 2 + longint'(o.sel);
      end
      if (o.srdyo === 1'b1) begin
        r = '{cur_e0[i], cyc, cur_macs[i], cur_sels[i], cur_acc[i]};
        if (i == 0) log_b.push_back(r);
        else        log_s.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int seen;
    rst_b = 1'b1;
    rst_s = 1'b1;
    bus_b.srdyi_i = 1'b0;
    bus_s.srdyi_i = 1'b0;
    idle(3);
    check("reset.big",   64'(act_o[0]), 64'd0);
    check("reset.small", 64'(act_o[1]), 64'd0);
    rst_b = 1'b0;
    rst_s = 1'b0;
    idle(2);

    // Single evaluation on both instances.
    log_b.delete();
    log_s.delete();
    bus_b.srdyi_i = 1'b1;
    bus_s.srdyi_i = 1'b1;
    step();
    bus_b.srdyi_i = 1'b0;
    bus_s.srdyi_i = 1'b0;
    idle(45);
    check("single.big.count", 64'(log_b.size()), 64'd1);
    check("single.small.count", 64'(log_s.size()), 64'd1);
    if (log_b.size() >= 1) begin
      check("single.big.latency", 64'(log_b[0].done - log_b[0].e0), 64'd35);
      check("single.big.macs",    64'(log_b[0].macs), 64'd11);
      check("single.big.sels",    log_b[0].sels, 64'hA9876543210);
      check("single.big.result",  64'(log_b[0].acc), 64'd18434);
    end
    if (log_s.size() >= 1) begin
      check("single.small.latency", 64'(log_s[0].done - log_s[0].e0), 64'd6);
      check("single.small.macs",    64'(log_s[0].macs), 64'd4);
      check("single.small.sels",    log_s[0].sels, 64'h3210);
      check("single.small.result",  64'(log_s[0].acc), 64'd34);
    end

    // Reset in the cycle of the 5th MAC aborts the evaluation; a fresh one follows.
    log_b.delete();
    bus_b.srdyi_i = 1'b1;
    step();
    bus_b.srdyi_i = 1'b0;
    seen = 0;
    for (int t = 0; t < 60 && seen < 5; t++) begin
      step();
      if (bus_b.mac_en_o === 1'b1) seen++;
    end
    check("abort.mac5_seen", 64'(seen), 64'd5);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("abort.outputs_cleared", 64'(act_o[0]), 64'd0);
    idle(2);
    bus_b.srdyi_i = 1'b1;
    step();
    bus_b.srdyi_i = 1'b0;
    idle(45);
    check("abort.count", 64'(log_b.size()), 64'd1);
    if (log_b.size() >= 1) begin
      check("abort.restart.latency", 64'(log_b[0].done - log_b[0].e0), 64'd35);
      check("abort.restart.result",  64'(log_b[0].acc), 64'd18434);
    end

    // Second request at E0+10 while busy.
    log_b.delete();
    bus_b.srdyi_i = 1'b1;
    step();
    bus_b.srdyi_i = 1'b0;
    idle(9);
    bus_b.srdyi_i = 1'b1;
    step();
    bus_b.srdyi_i = 1'b0;
    idle(80);
    check("busyreq.count", 64'(log_b.size()), PEND_EN ? 64'd2 : 64'd1);
    if (log_b.size() >= 1)
      check("busyreq.last_done", 64'(log_b[log_b.size()-1].done - log_b[0].e0),
            PEND_EN ? 64'd70 : 64'd35);

    // Request held high for 100 cycles.
    log_b.delete();
    bus_b.srdyi_i = 1'b1;
    idle(100);
    bus_b.srdyi_i = 1'b0;
    idle(80);
    check("held.count", 64'(log_b.size()), PEND_EN ? 64'd4 : 64'd3);
    if (log_b.size() >= 2) begin
      check("held.first_done",  64'(log_b[0].done - log_b[0].e0), 64'd35);
      check("held.second_done", 64'(log_b[1].done - log_b[0].e0), PEND_EN ? 64'd70 : 64'd71);
    end
    for (int k = 0; k < log_b.size(); k++)
      check($sformatf("held.macs[%0d]", k), 64'(log_b[k].macs), 64'd11);

    // Reset and request together: reset wins, nothing starts.
    rst_b = 1'b1;
    bus_b.srdyi_i = 1'b1;
    step();
    rst_b = 1'b0;
    bus_b.srdyi_i = 1'b0;
    check("rst_and_req.busy0", 64'(bus_b.busy_o), 64'd0);
    step();
    check("rst_and_req.busy1", 64'(bus_b.busy_o), 64'd0);

    // Randomised requests and occasional resets on both instances.
    for (int t = 0; t < 3000; t++) begin
      bus_b.srdyi_i = ($urandom_range(0, 9) == 0);
      bus_s.srdyi_i = ($urandom_range(0, 3) == 0);
      rst_b = ($urandom_range(0, 299) == 0);
      rst_s = ($urandom_range(0, 199) == 0);
      step();
    end
    bus_b.srdyi_i = 1'b0;
    bus_s.srdyi_i = 1'b0;
    rst_b = 1'b0;
    rst_s = 1'b0;
    idle(50);
    check("final.idle.big",   64'(act_o[0]), 64'd0);
    check("final.idle.small", 64'(act_o[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/horner_coeff_sequencer.md
Name: horner_coeff_sequencer

Overview:
- Sequencer that drives the 11-way coefficient mux select and the multiply-add datapath enables to evaluate a degree-10 polynomial by Horner's rule: y = (((c10·x + c9)·x + c8)…)·x + c0.
- Sits between the input handshake (srdyi_i) and the coefficient mux / MAC datapath; owns coeff_select ordering, accumulator clear, operand load and result-valid (srdyo_o).

Parameters:
- NUM_COEFF, 11, number of coefficients; legal 2..16; select runs NUM_COEFF-1 down to 0.
- SEL_W, 4, width of coeff_select_o; must satisfy 2^SEL_W >= NUM_COEFF.
- MUL_LAT, 2, datapath latency in cycles from mac_en_o to the updated accumulator; legal 0..7.

Ports:
- Clock  in  1  system clock, rising edge.
- GlobalReset  in  1  synchronous, active-high reset.
- srdyi_i  in  1  new operand x valid; request to start an evaluation.
- busy_o  out  1  high whenever state != IDLE.
- x_load_o  out  1  one-cycle strobe: datapath captures x.
- coeff_select_o  out  SEL_W  select driven to the coefficient mux.
- acc_clr_o  out  1  high with the first mac_en_o of an evaluation; datapath uses 0 instead of the accumulator as the addend base.
- mac_en_o  out  1  one-cycle strobe: datapath performs acc = acc·x + coeff.
- srdyo_o  out  1  one-cycle strobe: result valid on the datapath output.

Behaviour:
- All outputs registered. Reset value: busy_o=0, x_load_o=0, coeff_select_o=0, acc_clr_o=0, mac_en_o=0, srdyo_o=0; state=IDLE, step index=NUM_COEFF-1, wait counter=0.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: srdyi_i=1 sampled at edge E0 -> LOAD. Otherwise stay. srdyi_i is only accepted in IDLE (see optional feature).
- LOAD (1 cycle): x_load_o=1 -> ISSUE.
- ISSUE (1 cycle): coeff_select_o=step index, mac_en_o=1, acc_clr_o=1 only when step index = NUM_COEFF-1. If MUL_LAT>0 -> WAIT with counter=MUL_LAT-1; if MUL_LAT=0 -> ISSUE (next index) or DONE after index 0.
- WAIT: coeff_select_o holds the issued value, mac_en_o=0. Counter decrements each cycle. At 0 -> ISSUE with index-1, or DONE if the issued index was 0.
- DONE (1 cycle): srdyo_o=1, coeff_select_o=0 -> IDLE.
- coeff_select_o = 0 in IDLE, LOAD and DONE.
- Latency: srdyo_o is high in cycle E0 + 2 + NUM_COEFF·(1+MUL_LAT). Defaults: cycle E0+35. MUL_LAT=0: cycle E0+13.
- Exactly NUM_COEFF mac_en_o pulses per evaluation, with selects strictly descending and no repeats.
- srdyi_i while busy: ignored; no state change and no second srdyo_o.
- GlobalReset mid-evaluation: at the next edge all outputs go to reset values and state=IDLE. srdyo_o is never pulsed for the aborted evaluation. If srdyi_i and GlobalReset are high together, reset wins.
- srdyi_i held high continuously: a new evaluation is accepted in each IDLE cycle. Back-to-back spacing is one IDLE cycle between DONE and LOAD.

Optional Feature:
- Macro HORNER_PENDING_REQ_EN.
- Defined: a one-deep pending flag is set by srdyi_i while busy_o=1, including the DONE cycle. In DONE with pending=1, the next state is LOAD (not IDLE) and pending clears. Further requests while pending=1 are dropped. GlobalReset clears pending.
- Undefined: no pending flag; requests while busy are dropped as described above.

Test Plan:
- Reset, then srdyi_i pulse at cycle 5 (defaults) -> x_load_o at 6; mac_en_o at 7,10,…,37 with coeff_select_o 10,9,…,0; acc_clr_o only at 7; srdyo_o at 40; busy_o high 6..40.
- Bench MAC model with coeff_k=k, x=2 -> on srdyo_o, result = Σk·2^k = 18434.
- MUL_LAT=0, NUM_COEFF=4 -> mac_en_o on four consecutive cycles with selects 3,2,1,0; srdyo_o at E0+6.
- GlobalReset asserted at the cycle of the 5th mac_en_o -> next cycle all outputs 0, no srdyo_o; a new srdyi_i 2 cycles later -> full 35-cycle evaluation.
- srdyi_i pulse at E0+10 during busy -> without macro: single srdyo_o. With HORNER_PENDING_REQ_EN: second LOAD directly after DONE, second srdyo_o at E0+70.
- srdyi_i held high for 100 cycles -> srdyo_o at E0+35 and E0+71 (one IDLE gap); mac_en_o count per evaluation = 11.
